// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer and its clock divider.
package spi_ctrl_pkg;

    localparam int CHAR_LEN_BITS_DEF = 5;
    localparam int MAX_CHAR_DEF      = 32;
    localparam int DIV_W_DEF         = 16;

    localparam logic [3:0] LATCH_W0     = 4'b0001;
    localparam logic [3:0] BYTE_SEL_ALL = 4'hF;
    localparam logic [3:0] NIBBLE_ZERO  = 4'h0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        GO    = 3'd3,
        RUN   = 3'd4,
        HOLD  = 3'd5,
        RESP  = 3'd6
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: programmable half-period down-counter with one-cycle edge strobes.
module spi_clk_div
    import spi_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             s_clk,
    output logic             pos_edge,
    output logic             neg_edge
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_s_clk;
    logic             r_pos_edge;
    logic             r_neg_edge;
    logic             w_tick;

    // Counter sits at div while disabled, so the first toggle lands div+1 cycles after enable.
    assign w_tick = enable && (r_cnt == {DIV_W{1'b0}});

    // Counter, SCLK level and the strobes that announce each SCLK transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= {DIV_W{1'b0}};
            r_s_clk    <= 1'b0;
            r_pos_edge <= 1'b0;
            r_neg_edge <= 1'b0;
        end else begin
            if (!enable || w_tick) begin
                r_cnt <= div;
            end else begin
                r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
            end
            if (w_tick) begin
                r_s_clk <= !r_s_clk;
            end else begin
                r_s_clk <= r_s_clk;
            end
            r_pos_edge <= w_tick && !r_s_clk;
            r_neg_edge <= w_tick && r_s_clk;
        end
    end

    assign s_clk    = r_s_clk;
    assign pos_edge = r_pos_edge;
    assign neg_edge = r_neg_edge;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI character sequencer: accepts one command, drives the shift register controls,
// SCLK and slave select, then returns the received word on a valid/ready channel.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CHAR_LEN_BITS = CHAR_LEN_BITS_DEF,
    parameter int MAX_CHAR      = MAX_CHAR_DEF,
    parameter int DIV_W         = DIV_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [MAX_CHAR-1:0]      cmd_data,
    input  logic [CHAR_LEN_BITS-1:0] cmd_len,
    input  logic                     cmd_lsb,
    input  logic                     cmd_rx_neg,
    input  logic                     cmd_tx_neg,
    input  logic [DIV_W-1:0]         cmd_div,
    input  logic                     cmd_keep_ss,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MAX_CHAR-1:0]      rsp_data,
    output logic                     busy,
    output logic [3:0]               sh_latch,
    output logic [3:0]               sh_byte_sel,
    output logic [MAX_CHAR-1:0]      sh_p_in,
    output logic [CHAR_LEN_BITS-1:0] sh_len,
    output logic                     sh_lsb,
    output logic                     sh_rx_negedge,
    output logic                     sh_tx_negedge,
    output logic                     sh_go,
    output logic                     sh_pos_edge,
    output logic                     sh_neg_edge,
    output logic                     s_clk,
    input  logic                     sh_tip,
    input  logic [MAX_CHAR-1:0]      sh_p_out,
    output logic                     ss_n
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_busy;
    logic                     r_cmd_ready;
    logic [3:0]               r_latch;
    logic [3:0]               r_byte_sel;
    logic                     r_go;
    logic [MAX_CHAR-1:0]      r_data;
    logic [CHAR_LEN_BITS-1:0] r_len;
    logic                     r_lsb;
    logic                     r_rx_neg;
    logic                     r_tx_neg;
    logic [DIV_W-1:0]         r_div;
    logic                     r_keep;
    logic [DIV_W-1:0]         r_wait_cnt;
    logic                     r_ss_n;
    logic                     r_rsp_valid;
    logic [MAX_CHAR-1:0]      r_rsp_data;
    logic                     w_accept;
    logic                     w_run_done;
    logic                     w_clk_en;
    logic                     w_wait_zero;
    logic                     w_s_clk;
    logic                     w_pos_edge;
    logic                     w_neg_edge;

    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_run_done  = !sh_tip && !w_s_clk;
    // Divider is gated off in the exit cycle so no edge can leak into HOLD.
    assign w_clk_en    = (r_state == RUN) && !w_run_done;
    assign w_wait_zero = (r_wait_cnt == {DIV_W{1'b0}});

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .enable   (w_clk_en),
        .div      (r_div),
        .s_clk    (w_s_clk),
        .pos_edge (w_pos_edge),
        .neg_edge (w_neg_edge)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = LOAD;  else w_state_nxt = IDLE;
            LOAD:    w_state_nxt = SETUP;
            SETUP:   if (w_wait_zero) w_state_nxt = GO;    else w_state_nxt = SETUP;
            GO:      w_state_nxt = RUN;
            RUN:     if (w_run_done)  w_state_nxt = HOLD;  else w_state_nxt = RUN;
            HOLD:    if (w_wait_zero) w_state_nxt = RESP;  else w_state_nxt = HOLD;
            RESP:    if (rsp_ready)   w_state_nxt = IDLE;  else w_state_nxt = RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register plus outputs decoded from the next state so they leave flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_latch     <= NIBBLE_ZERO;
            r_byte_sel  <= NIBBLE_ZERO;
            r_go        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_latch     <= (w_state_nxt == LOAD) ? LATCH_W0 : NIBBLE_ZERO;
            r_byte_sel  <= (w_state_nxt == LOAD) ? BYTE_SEL_ALL : NIBBLE_ZERO;
            r_go        <= (w_state_nxt == GO);
            r_rsp_valid <= (w_state_nxt == RESP);
        end
    end

    // Command capture, SETUP/HOLD wait counter, slave select and response word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= {MAX_CHAR{1'b0}};
            r_len      <= {CHAR_LEN_BITS{1'b0}};
            r_lsb      <= 1'b0;
            r_rx_neg   <= 1'b0;
            r_tx_neg   <= 1'b0;
            r_div      <= {DIV_W{1'b0}};
            r_keep     <= 1'b0;
            r_wait_cnt <= {DIV_W{1'b0}};
            r_ss_n     <= 1'b1;
            r_rsp_data <= {MAX_CHAR{1'b0}};
        end else begin
            if (w_accept) begin
                r_data   <= cmd_data;
                r_len    <= cmd_len;
                r_lsb    <= cmd_lsb;
                r_rx_neg <= cmd_rx_neg;
                r_tx_neg <= cmd_tx_neg;
                r_div    <= cmd_div;
                r_keep   <= cmd_keep_ss;
            end
            if ((r_state == LOAD) || ((r_state == RUN) && w_run_done)) begin
                r_wait_cnt <= r_div;
            end else if (!w_wait_zero) begin
                r_wait_cnt <= r_wait_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
            end
            if (r_state == LOAD) begin
                r_ss_n <= 1'b0;
            end else if ((r_state == HOLD) && (w_state_nxt == RESP)) begin
                r_ss_n <= !r_keep;
            end
            if ((r_state == HOLD) && (w_state_nxt == RESP)) begin
                r_rsp_data <= sh_p_out;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign sh_latch      = r_latch;
    assign sh_byte_sel   = r_byte_sel;
    assign sh_p_in       = r_data;
    assign sh_len        = r_len;
    assign sh_lsb        = r_lsb;
    assign sh_rx_negedge = r_rx_neg;
    assign sh_tx_negedge = r_tx_neg;
    assign sh_go         = r_go;
    assign sh_pos_edge   = w_pos_edge;
    assign sh_neg_edge   = w_neg_edge;
    assign s_clk         = w_s_clk;
    assign ss_n          = r_ss_n;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback shift-register model, table vectors, random commands
// and hand sequences for reset-in-flight, response stall and held slave select.
module tb_spi_xfer_ctrl;

    // Narrower divider keeps the all-ones divisor case short while still exercising the maximum count.
    localparam int TB_DIV_W  = 12;
    localparam int RSP_LIMIT = 40000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [31:0]         cmd_data = 32'h0;
    logic [4:0]          cmd_len = 5'd0;
    logic                cmd_lsb = 1'b0;
    logic                cmd_rx_neg = 1'b0;
    logic                cmd_tx_neg = 1'b0;
    logic [TB_DIV_W-1:0] cmd_div = '0;
    logic                cmd_keep_ss = 1'b0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [31:0]         rsp_data;
    logic                busy;
    logic [3:0]          sh_latch;
    logic [3:0]          sh_byte_sel;
    logic [31:0]         sh_p_in;
    logic [4:0]          sh_len;
    logic                sh_lsb, sh_rx_negedge, sh_tx_negedge, sh_go;
    logic                sh_pos_edge, sh_neg_edge, s_clk, ss_n;
    logic                sh_tip;
    logic [31:0]         sh_p_out;

    spi_xfer_ctrl #(.CHAR_LEN_BITS(5), .MAX_CHAR(32), .DIV_W(TB_DIV_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_lsb(cmd_lsb),
        .cmd_rx_neg(cmd_rx_neg), .cmd_tx_neg(cmd_tx_neg), .cmd_div(cmd_div),
        .cmd_keep_ss(cmd_keep_ss), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel),
        .sh_p_in(sh_p_in), .sh_len(sh_len), .sh_lsb(sh_lsb), .sh_rx_negedge(sh_rx_negedge),
        .sh_tx_negedge(sh_tx_negedge), .sh_go(sh_go), .sh_pos_edge(sh_pos_edge),
        .sh_neg_edge(sh_neg_edge), .s_clk(s_clk), .sh_tip(sh_tip), .sh_p_out(sh_p_out),
        .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nbits_of(input logic [4:0] len);
        return (len == 5'd0) ? 32 : int'(len) + 1;
    endfunction

    function automatic logic [31:0] char_mask(input logic [4:0] len);
        int n;
        logic [31:0] one;
        n   = nbits_of(len);
        one = 32'h1;
        return (n == 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h1);
    endfunction

    function automatic int bitpos(input logic lsb, input int n, input int k);
        return lsb ? k : (n - 1 - k);
    endfunction

    // Shift register model with s_out looped to s_in: tip spans go .. n-th rising edge,
    // each sampling edge copies the transmitted bit into an initially clear receive word.
    logic [31:0] m_tx, m_rx;
    int          m_npos_tip, m_nrx;
    assign sh_p_out = m_rx;

    always @(posedge clk) begin
        if (rst) begin
            sh_tip     <= 1'b0;
            m_tx       <= 32'h0;
            m_rx       <= 32'h0;
            m_npos_tip <= 0;
            m_nrx      <= 0;
        end else begin
            if (sh_latch[0] && sh_byte_sel == 4'hF) begin
                m_tx <= sh_p_in;
                m_rx <= 32'h0;
            end
            if (sh_go && !sh_tip) begin
                sh_tip     <= 1'b1;
                m_npos_tip <= 0;
                m_nrx      <= 0;
            end else begin
                if (sh_tip && sh_pos_edge) begin
                    m_npos_tip <= m_npos_tip + 1;
                    if (m_npos_tip == nbits_of(sh_len) - 1) sh_tip <= 1'b0;
                end
                if ((sh_rx_negedge ? sh_neg_edge : sh_pos_edge) && m_nrx < nbits_of(sh_len)) begin
                    m_rx[bitpos(sh_lsb, nbits_of(sh_len), m_nrx)] <= m_tx[bitpos(sh_lsb, nbits_of(sh_len), m_nrx)];
                    m_nrx <= m_nrx + 1;
                end
            end
        end
    end

    // Per-transfer observations, restarted at each load strobe.
    int          cur_div = 0;
    int          m_latch, m_go, m_first_pos, m_last_pos, m_npos, m_nneg, m_gap_bad, m_ss_bad;
    int          m_strobe_bad = 0;
    logic [31:0] m_pin;
    logic [3:0]  m_bsel;

    always @(negedge clk) begin
        if (!rst && sh_latch[0]) begin
            m_latch   <= cyc;
            m_npos    <= 0;
            m_nneg    <= 0;
            m_gap_bad <= 0;
            m_ss_bad  <= 0;
            m_pin     <= sh_p_in;
            m_bsel    <= sh_byte_sel;
        end else begin
            if (sh_go) m_go <= cyc;
            if (sh_pos_edge) begin
                if (m_npos == 0) m_first_pos <= cyc;
                else if (cyc - m_last_pos != 2 * (cur_div + 1)) m_gap_bad <= m_gap_bad + 1;
                m_last_pos <= cyc;
                m_npos     <= m_npos + 1;
            end
            if (sh_neg_edge) m_nneg <= m_nneg + 1;
            if (ss_n && busy && !rsp_valid) m_ss_bad <= m_ss_bad + 1;
        end
        if ((sh_pos_edge && sh_neg_edge) || ((sh_pos_edge || sh_neg_edge) && !busy))
            m_strobe_bad <= m_strobe_bad + 1;
    end

    typedef struct {
        logic [31:0]         data;
        logic [4:0]          len;
        logic                lsb;
        logic                rxn;
        logic                txn;
        logic [TB_DIV_W-1:0] div;
        logic                keep;
        int                  stall;
        logic [31:0]         exp_rsp;
        int                  exp_n;
    } vec_t;

    logic prev_keep = 1'b0;

    task automatic run_cmd(input string tag, input vec_t v);
        int a_cyc, k, bad, d, n;
        logic [31:0] held;
        d = int'(v.div);
        n = v.exp_n;
        cur_div = d;
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
        check({tag, ".cmd_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_data = v.data; cmd_len = v.len; cmd_lsb = v.lsb;
        cmd_rx_neg = v.rxn; cmd_tx_neg = v.txn; cmd_div = v.div; cmd_keep_ss = v.keep;
        a_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ".busy_in_load"}, busy, 1);
        check({tag, ".ss_n_in_load"}, ss_n, prev_keep ? 0 : 1);
        k = 0;
        while (!rsp_valid && k < RSP_LIMIT) begin @(negedge clk); k++; end
        check({tag, ".rsp_latency"}, cyc - a_cyc, 6 + 2 * d + 2 * n * (d + 1));
        held = rsp_data;
        bad = 0;
        for (int i = 0; i < v.stall; i++) begin
            cmd_valid = 1'b1; cmd_data = ~v.data; cmd_len = ~v.len; cmd_lsb = ~v.lsb;
            cmd_rx_neg = ~v.rxn; cmd_tx_neg = ~v.txn; cmd_div = ~v.div;
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || cmd_ready || sh_latch[0] || !busy) bad++;
        end
        cmd_valid = 1'b0;
        if (v.stall > 0) check({tag, ".stall_hold"}, bad, 0);
        check({tag, ".rsp_data"}, rsp_data, v.exp_rsp);
        check({tag, ".ss_n_resp"}, ss_n, v.keep ? 0 : 1);
        check({tag, ".s_clk_low"}, s_clk, 0);
        check({tag, ".modes"}, {sh_len, sh_lsb, sh_rx_negedge, sh_tx_negedge},
              {v.len, v.lsb, v.rxn, v.txn});
        check({tag, ".load_word"}, {m_bsel, m_pin}, {4'hF, v.data});
        check({tag, ".latch_to_go"}, m_go - m_latch, d + 2);
        check({tag, ".go_to_first_pos"}, m_first_pos - m_go, d + 2);
        check({tag, ".pos_count"}, m_npos, n);
        check({tag, ".neg_count"}, m_nneg, n);
        check({tag, ".pos_spacing"}, m_gap_bad, 0);
        check({tag, ".ss_low_active"}, m_ss_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".idle_after"}, {cmd_ready, busy, rsp_valid, ss_n}, {1'b1, 1'b0, 1'b0, !v.keep});
        prev_keep = v.keep;
    endtask

    vec_t vecs[8];
    vec_t v;
    int   k;

    initial begin
        vecs[0] = '{32'h000000A5, 5'd7,  1'b0, 1'b0, 1'b1, 12'd1,   1'b0, 0,  32'h000000A5, 8};
        vecs[1] = '{32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 0,  32'hDEADBEEF, 32};
        vecs[2] = '{32'h12345678, 5'd3,  1'b1, 1'b1, 1'b0, 12'd2,   1'b0, 0,  32'h00000008, 4};
        vecs[3] = '{32'hFFFF1234, 5'd15, 1'b1, 1'b1, 1'b1, 12'd0,   1'b0, 0,  32'h00001234, 16};
        vecs[4] = '{32'h0F0F0F0F, 5'd31, 1'b0, 1'b0, 1'b1, 12'd0,   1'b1, 0,  32'h0F0F0F0F, 32};
        vecs[5] = '{32'h0000003E, 5'd1,  1'b0, 1'b0, 1'b0, 12'd1,   1'b0, 0,  32'h00000002, 2};
        vecs[6] = '{32'hCAFEF00D, 5'd7,  1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 10, 32'h0000000D, 8};
        vecs[7] = '{32'h00000001, 5'd1,  1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0, 0,  32'h00000001, 2};

        repeat (3) @(negedge clk);
        check("reset_state", {cmd_ready, busy, rsp_valid, ss_n, s_clk, sh_go, sh_latch, sh_byte_sel},
              {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 10; i++) begin
            v.data    = $urandom;
            v.len     = 5'($urandom_range(0, 31));
            v.lsb     = 1'($urandom_range(0, 1));
            v.rxn     = 1'($urandom_range(0, 1));
            v.txn     = 1'($urandom_range(0, 1));
            v.div     = TB_DIV_W'($urandom_range(0, 3));
            v.keep    = 1'($urandom_range(0, 1));
            v.stall   = $urandom_range(0, 3);
            v.exp_rsp = v.data & char_mask(v.len);
            v.exp_n   = nbits_of(v.len);
            run_cmd($sformatf("rnd%0d", i), v);
        end

        // Reset while SCLK is high mid-character.
        cmd_valid = 1'b1; cmd_data = 32'h5A5A5A5A; cmd_len = 5'd7; cmd_lsb = 1'b0;
        cmd_rx_neg = 1'b0; cmd_tx_neg = 1'b0; cmd_div = 12'd3; cmd_keep_ss = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(s_clk && busy) && k < 500) begin @(negedge clk); k++; end
        check("rst_pre_active", {s_clk, ss_n, busy}, {1'b1, 1'b0, 1'b1});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_run", {s_clk, ss_n, busy, cmd_ready, rsp_valid, sh_pos_edge, sh_neg_edge},
              {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        prev_keep = 1'b0;
        @(negedge clk);
        run_cmd("after_rst", vecs[0]);

        check("strobe_rules", m_strobe_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
